// File: rtl/nios2_oci_dct_pkg.sv
// Shared types and constants for the OCI trace-fragment packing sequencer.
package nios2_oci_dct_pkg;

    localparam int FRAG_W = 3;
    localparam int SLOTS  = 10;
    localparam int BUF_W  = FRAG_W * SLOTS;
    localparam int CNT_W  = 4;

    localparam logic [1:0] TAG_FULL    = 2'b01;
    localparam logic [1:0] TAG_PARTIAL = 2'b10;

    typedef enum logic [1:0] {
        FILL  = 2'b00,
        EMIT  = 2'b01,
        ENDED = 2'b10
    } state_t;

endpackage

// File: rtl/nios2_oci_dct_timeout.sv
// Idle counter: flags a partially filled buffer that has waited TIMEOUT_CYCLES-1 cycles.
module nios2_oci_dct_timeout #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_q;

    assign expired = (count_q == 8'(TIMEOUT_CYCLES - 1));

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule

// File: rtl/nios2_oci_dct_sequencer.sv
// Packs 3-bit trace fragments into 30-bit words, emitting on full, idle timeout or test end.
module nios2_oci_dct_sequencer
    import nios2_oci_dct_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frag_valid,
    input  logic [FRAG_W-1:0] frag_data,
    output logic              frag_ready,
    output logic              tw_valid,
    input  logic              tw_ready,
    output logic [35:0]       tw_data,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    input  logic              test_ending,
    output logic              test_has_ended
);

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buffer_d;
    logic [CNT_W-1:0]   count_d;
    logic [1:0]         tag_q, tag_d;
    logic               ending_q;
    logic               accept;
    logic               expired;

    assign frag_ready     = (state_q == FILL) && !ending_q;
    assign accept         = frag_valid && frag_ready;
    assign tw_valid       = (state_q == EMIT);
    assign test_has_ended = (state_q == ENDED);
    assign tw_data        = tw_valid ? {tag_q, dct_count, dct_buffer} : '0;

    nios2_oci_dct_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept || (dct_count == '0) || (state_q != FILL)),
        .enable  ((state_q == FILL) && !accept),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FILL;
            dct_buffer <= '0;
            dct_count  <= '0;
            tag_q      <= '0;
            ending_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dct_buffer <= buffer_d;
            dct_count  <= count_d;
            tag_q      <= tag_d;
            if (test_ending) begin
                ending_q <= 1'b1;
            end
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case can leave a variable unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        buffer_d = dct_buffer;
        count_d  = dct_count;
        tag_d    = tag_q;
        unique case (state_q)
            FILL: begin
                // A fresh fragment wins over ending and timeout; full beats timeout.
                if (accept) begin
                    buffer_d[FRAG_W*int'(dct_count) +: FRAG_W] = frag_data;
                    count_d = dct_count + 4'd1;
                    if (count_d == CNT_W'(SLOTS)) begin
                        state_d = EMIT;
                        tag_d   = TAG_FULL;
                    end
                end else if (ending_q) begin
                    if (dct_count != '0) begin
                        state_d = EMIT;
                        tag_d   = TAG_PARTIAL;
                    end else begin
                        state_d = ENDED;
                    end
                end else if (expired) begin
                    state_d = EMIT;
                    tag_d   = TAG_PARTIAL;
                end
            end
            EMIT: begin
                if (tw_ready) begin
                    buffer_d = '0;
                    count_d  = '0;
                    tag_d    = '0;
                    state_d  = ending_q ? ENDED : FILL;
                end
            end
            ENDED: begin
                state_d = ENDED;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

endmodule

// File: tb/tb_nios2_oci_dct_sequencer.sv
// Directed bench for the fragment packing sequencer (TIMEOUT_CYCLES = 4).
module tb_nios2_oci_dct_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frag_valid;
    logic [2:0]  frag_data;
    logic        frag_ready;
    logic        tw_valid;
    logic        tw_ready;
    logic [35:0] tw_data;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;

    int n_checks = 0;
    int n_errors = 0;

    nios2_oci_dct_sequencer #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frag_valid     (frag_valid),
        .frag_data      (frag_data),
        .frag_ready     (frag_ready),
        .tw_valid       (tw_valid),
        .tw_ready       (tw_ready),
        .tw_data        (tw_data),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [2:0] d);
        frag_valid = 1'b1;
        frag_data  = d;
        tick();
        frag_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    logic [2:0]  vals_a [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    logic [2:0]  vals_b [10] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
    logic [35:0] word_b;

    initial begin
        reset_n     = 1'b0;
        frag_valid  = 1'b0;
        frag_data   = '0;
        tw_ready    = 1'b0;
        test_ending = 1'b0;
        word_b      = {2'b01, 4'd10, 30'o6701234567};

        // Reset state
        #2;
        check("rst_tw_valid", tw_valid, 0);
        check("rst_tw_data", tw_data, 0);
        check("rst_buffer", dct_buffer, 0);
        check("rst_count", dct_count, 0);
        check("rst_ended", test_has_ended, 0);
        check("rst_frag_ready", frag_ready, 1);
        tick();
        reset_n = 1'b1;
        tick();

        // Full word, consumer always ready
        tw_ready = 1'b1;
        for (int i = 0; i < 9; i++) feed(vals_a[i]);
        check("full_pre_valid", tw_valid, 0);
        check("full_pre_count", dct_count, 9);
        feed(vals_a[9]);
        check("full_valid", tw_valid, 1);
        check("full_data", tw_data, {2'b01, 4'd10, 30'o2107654321});
        check("full_frag_ready", frag_ready, 0);
        tick();
        check("full_one_cycle", tw_valid, 0);
        check("full_clr_count", dct_count, 0);
        check("full_clr_buffer", dct_buffer, 0);

        // Back-pressure: word held stable while tw_ready low
        tw_ready = 1'b0;
        for (int i = 0; i < 10; i++) feed(vals_b[i]);
        frag_valid = 1'b1;
        frag_data  = 3'd5;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", tw_valid, 1);
            check("bp_data", tw_data, word_b);
            check("bp_frag_ready", frag_ready, 0);
            tick();
        end
        frag_valid = 1'b0;
        tw_ready   = 1'b1;
        check("bp_hold_data", tw_data, word_b);
        tick();
        check("bp_clr_valid", tw_valid, 0);
        check("bp_clr_count", dct_count, 0);
        tw_ready = 1'b0;

        // Idle timeout with three fragments
        feed(3'd5);
        feed(3'd3);
        feed(3'd6);
        check("to_count", dct_count, 3);
        check("to_buffer", dct_buffer, 30'o635);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_wait_valid", tw_valid, 0);
        end
        tick();
        check("to_valid", tw_valid, 1);
        check("to_data", tw_data, {2'b10, 4'd3, 30'o635});
        check("to_upper_zero", dct_buffer[29:9], 0);
        tw_ready = 1'b1;
        tick();
        check("to_clr_valid", tw_valid, 0);
        tw_ready = 1'b0;

        // test_ending with two fragments held
        feed(3'd4);
        feed(3'd2);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        check("end_frag_ready", frag_ready, 0);
        tick();
        check("end_valid", tw_valid, 1);
        check("end_data", tw_data, {2'b10, 4'd2, 30'o24});
        tw_ready = 1'b1;
        tick();
        tw_ready = 1'b0;
        check("end_has_ended", test_has_ended, 1);
        check("end_tw_valid", tw_valid, 0);
        frag_valid = 1'b1;
        frag_data  = 3'd7;
        for (int i = 0; i < 3; i++) tick();
        frag_valid = 1'b0;
        check("end_sticky", test_has_ended, 1);
        check("end_ignored_count", dct_count, 0);
        check("end_ignored_ready", frag_ready, 0);
        do_reset();
        check("end_reset_clears", test_has_ended, 0);

        // test_ending together with the 10th fragment
        for (int i = 0; i < 9; i++) feed(vals_a[i]);
        test_ending = 1'b1;
        feed(vals_a[9]);
        test_ending = 1'b0;
        check("endfull_valid", tw_valid, 1);
        check("endfull_data", tw_data, {2'b01, 4'd10, 30'o2107654321});
        tw_ready = 1'b1;
        tick();
        tw_ready = 1'b0;
        check("endfull_ended", test_has_ended, 1);
        check("endfull_tw_valid", tw_valid, 0);
        do_reset();

        // Reset asserted in the middle of EMIT
        for (int i = 0; i < 10; i++) feed(vals_b[i]);
        check("mid_valid_pre", tw_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", tw_valid, 0);
        check("mid_rst_data", tw_data, 0);
        check("mid_rst_count", dct_count, 0);
        check("mid_rst_buffer", dct_buffer, 0);
        check("mid_rst_ended", test_has_ended, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("mid_post_valid", tw_valid, 0);
        check("mid_post_ready", frag_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nios2_oci_dct_sequencer.md
NIOS2_OCI_DCT_SEQUENCER -- requirements
Module: nios2_oci_dct_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64, meaning idle cycles before a partial buffer is flushed (legal range 2..255).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1 bit: sole clock, rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port frag_valid, input, 1 bit: trace fragment offered.
REQ-006 Port frag_data, input, 3 bits: trace fragment payload.
REQ-007 Port frag_ready, output, 1 bit: fragment accepted on a cycle where frag_valid and frag_ready are both high.
REQ-008 Port tw_valid, output, 1 bit: trace word available.
REQ-009 Port tw_ready, input, 1 bit: trace word consumed on a cycle where tw_valid and tw_ready are both high.
REQ-010 Port tw_data, output, 36 bits: {tag[1:0], dct_count[3:0], dct_buffer[29:0]}.
REQ-011 Port dct_buffer, output, 30 bits: packing register, observable by the OCI test bench.
REQ-012 Port dct_count, output, 4 bits: fragments held in the packing register, 0..10.
REQ-013 Port test_ending, input, 1 bit: request to drain and stop; a one-cycle pulse is sufficient.
REQ-014 Port test_has_ended, output, 1 bit: drain complete; stays high until reset.

Function
REQ-015 The block SHALL use three states: FILL, EMIT and ENDED.
REQ-016 frag_ready SHALL be 1 only when the state is FILL and ending_q is 0.
REQ-017 On accept, dct_buffer[3*dct_count +: 3] SHALL take frag_data and dct_count SHALL increment; fragment 0 occupies bits [2:0].
REQ-018 The accept that makes dct_count 10 SHALL move the state to EMIT with tag 2'b01 (FULL); tw_valid SHALL rise on the next cycle, giving 1-cycle latency.
REQ-019 In EMIT, tw_valid SHALL be 1, frag_ready SHALL be 0, and tw_data SHALL stay stable until tw_ready is sampled high.
REQ-020 On the EMIT handshake, dct_buffer and dct_count SHALL clear to 0, and the next state SHALL be ENDED if ending_q is 1, otherwise FILL.
REQ-021 The idle counter SHALL count cycles in FILL with dct_count>0 and no accept; it SHALL clear on any accept and whenever dct_count is 0.
REQ-022 When the idle counter reaches TIMEOUT_CYCLES-1, the state SHALL move to EMIT with tag 2'b10 (PARTIAL), keeping the partial dct_count.
REQ-023 test_ending SHALL set the sticky flag ending_q.
REQ-024 In FILL with ending_q set: if dct_count>0, the state SHALL move to EMIT with tag 2'b10; if dct_count==0, it SHALL move to ENDED.
REQ-025 If frag_valid and test_ending are high in the same FILL cycle, the fragment SHALL be accepted and the ending SHALL take effect on the following cycle.
REQ-026 In ENDED, test_has_ended SHALL be 1, and frag_ready and tw_valid SHALL be 0; only reset leaves ENDED.
REQ-027 Timeout and full SHALL never coincide; the full condition takes priority.
REQ-028 Unused bits of dct_buffer above 3*dct_count SHALL read 0.

Reset
REQ-029 While reset_n is 0: state FILL, dct_buffer 0, dct_count 0, idle counter 0, ending_q 0, tw_valid 0, tw_data 0, test_has_ended 0.
REQ-030 Reset asserted mid-EMIT SHALL drop tw_valid immediately and discard the pending word.

Structure
REQ-031 Package nios2_oci_dct_pkg SHALL hold the state encoding, TAG_FULL=2'b01, TAG_PARTIAL=2'b10, FRAG_W=3 and SLOTS=10.
REQ-032 The idle counter SHALL be the single sub-module nios2_oci_dct_timeout, with inputs clk, reset_n, clear, enable and output expired.

Verification
REQ-033 Ten accepts of values 1..7,0,1,2 with tw_ready=1 -> tw_valid for exactly one cycle, 1 cycle after the 10th accept; tw_data = {01, 1010, 30'o2107654321}.
REQ-034 Full buffer with tw_ready=0 for 5 cycles -> tw_data stable, frag_ready=0 throughout, clear on the 6th-cycle handshake.
REQ-035 Three fragments then idle, TIMEOUT_CYCLES=4 -> EMIT 4 cycles after the last accept with tag 10, count 0011, upper 21 buffer bits 0.
REQ-036 test_ending pulse with 2 fragments held -> PARTIAL word emitted, then test_has_ended=1 sticky; later frag_valid is ignored.
REQ-037 test_ending together with the 10th fragment -> FULL word emitted, then ENDED; reset_n low mid-EMIT -> all outputs 0 in the same cycle.
